regfile_wr_decode: RTL and testbench

Write-side register file for the pipelined CPU: 32 × 64-bit architectural registers. The write-back stage's 5-bit register number is decoded into one-hot per-register write enables. Two read ports return register contents through 32:1 selection. X31 is the hardwired zero register. The block sits between the write-back stage, which is the write port, and the decode stage, which uses the read ports.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/decoder5_32.sv | 26 ++
 rtl/regfile_wr_decode.sv | 105 ++++++++++
 tb/tb_regfile_wr_decode.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared constants and types for the pipelined CPU datapath.
//            Holds the architectural register file geometry, the index of
//            the hardwired-zero register, and the register-address and
//            data-word types.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd31;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_WIDTH-1:0] word_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/decoder5_32.sv
`default_nettype none
// ============================================================================
// Module   : decoder5_32
// Purpose  : 5-to-32 one-hot decoder with enable.
// Ports    : sel_i  - 5-bit index to decode
//            en_i   - enable; output is all-zero when low
//            dec_o  - 32-bit one-hot result (bit sel_i set when en_i = 1)
// Revision : 1.0 - initial release
// ============================================================================
module decoder5_32
    import cpu_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] sel_i,
    input  logic                  en_i,
    output logic [NUM_REGS-1:0]   dec_o
);

    always_comb begin
        dec_o = '0;
        if (en_i) begin
            dec_o[sel_i] = 1'b1;
        end
    end

endmodule : decoder5_32
`default_nettype wire

// File: rtl/regfile_wr_decode.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wr_decode
// Purpose  : Architectural register file (32 x 64-bit) with one write port
//            and two combinational read ports. X31 is hardwired to zero.
//            A read of the register being written in the same cycle returns
//            WriteData (write-through bypass) so write-back and decode can
//            overlap without a separate forwarding stage.
// Ports    : clk            - clock, all state updates on rising edge
//            reset          - synchronous active-high clear of all registers
//            RegWrite       - write enable from write-back stage
//            WriteRegister  - destination register number
//            WriteData      - value to write
//            ReadRegister1/2- read port register numbers
//            ReadData1/2    - read port data (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wr_decode #(
    parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
    parameter int NUM_REGS   = cpu_pkg::NUM_REGS,
    parameter int ZERO_REG   = 31
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          RegWrite,
    input  logic [$clog2(NUM_REGS)-1:0]   WriteRegister,
    input  logic [DATA_WIDTH-1:0]         WriteData,
    input  logic [$clog2(NUM_REGS)-1:0]   ReadRegister1,
    input  logic [$clog2(NUM_REGS)-1:0]   ReadRegister2,
    output logic [DATA_WIDTH-1:0]         ReadData1,
    output logic [DATA_WIDTH-1:0]         ReadData2
);

    localparam int ADDR_W = $clog2(NUM_REGS);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [NUM_REGS-1:0]   dec_en;
    logic [NUM_REGS-1:0]   wr_en;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

    logic                  bypass1;
    logic                  bypass2;

    // ------------------------------------------------------------------
    // Write decode: one-hot enables, zero register never enabled
    // ------------------------------------------------------------------
    decoder5_32 u_wr_dec (
        .sel_i (WriteRegister),
        .en_i  (RegWrite),
        .dec_o (dec_en)
    );

    always_comb begin
        wr_en            = dec_en;
        wr_en[ZERO_ADDR] = 1'b0;
    end

    // ------------------------------------------------------------------
    // Storage. The zero-register slot is never enabled, so it stays at its
    // reset value and collapses to a constant in synthesis.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_en[i]) begin
                    regs_q[i] <= WriteData;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read ports. Bypass depends only on RegWrite and address match, so it
    // stays active while reset is asserted; reads themselves are not gated
    // by reset and show pre-reset contents until the clearing edge.
    // ------------------------------------------------------------------
    assign bypass1 = RegWrite && (WriteRegister == ReadRegister1);
    assign bypass2 = RegWrite && (WriteRegister == ReadRegister2);

    always_comb begin
        if (ReadRegister1 == ZERO_ADDR) begin
            ReadData1 = '0;
        end else if (bypass1) begin
            ReadData1 = WriteData;
        end else begin
            ReadData1 = regs_q[ReadRegister1];
        end
    end

    always_comb begin
        if (ReadRegister2 == ZERO_ADDR) begin
            ReadData2 = '0;
        end else if (bypass2) begin
            ReadData2 = WriteData;
        end else begin
            ReadData2 = regs_q[ReadRegister2];
        end
    end

endmodule : regfile_wr_decode
`default_nettype wire

// File: tb/tb_regfile_wr_decode.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wr_decode
// Purpose  : Self-checking bench for regfile_wr_decode. A plain array holds
//            the architectural register contents; expected read data is
//            derived from it plus the bypass and zero-register rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wr_decode;

    logic        clk;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [63:0] ReadData1;
    logic [63:0] ReadData2;

    int errors;
    int checks;

    logic [63:0] model [32];

    regfile_wr_decode #(
        .DATA_WIDTH (64),
        .NUM_REGS   (32),
        .ZERO_REG   (31)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected read value: X31 is zero, a same-cycle write to the addressed
    // register is seen directly, otherwise the stored architectural value.
    function automatic logic [63:0] exp_rd(input logic [4:0] a);
        if (a == 5'd31) return 64'd0;
        if (RegWrite && WriteRegister == a) return WriteData;
        return model[a];
    endfunction

    // Advance one clock edge and apply the architectural update rules.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) model[i] = 64'd0;
        end else if (RegWrite && WriteRegister != 5'd31) begin
            model[WriteRegister] = WriteData;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; RegWrite = 1'b0;
        tick();
        reset = 1'b0;
        for (int a = 0; a < 32; a++) begin
            ReadRegister1 = 5'(a);
            ReadRegister2 = 5'(31 - a);
            #1;
            checks++;
            if (ReadData1 !== 64'd0) begin
                errors++;
                $display("FAIL reset_rd1 addr=%0d got=%h exp=%h", a, ReadData1, 64'd0);
            end
            checks++;
            if (ReadData2 !== 64'd0) begin
                errors++;
                $display("FAIL reset_rd2 addr=%0d got=%h exp=%h", 31 - a, ReadData2, 64'd0);
            end
        end
    endtask

    task automatic test_write_read();
        RegWrite = 1'b1; WriteRegister = 5'd5; WriteData = 64'hDEAD_BEEF_0000_0001;
        ReadRegister1 = 5'd0; ReadRegister2 = 5'd0;
        tick();
        RegWrite = 1'b0; WriteData = 64'd0;
        ReadRegister1 = 5'd5;
        #1;
        checks++;
        if (ReadData1 !== 64'hDEAD_BEEF_0000_0001) begin
            errors++;
            $display("FAIL write_x5 got=%h exp=%h", ReadData1, 64'hDEAD_BEEF_0000_0001);
        end
        for (int a = 0; a < 32; a++) begin
            if (a == 5) continue;
            ReadRegister2 = 5'(a);
            #1;
            checks++;
            if (ReadData2 !== 64'd0) begin
                errors++;
                $display("FAIL write_others addr=%0d got=%h exp=%h", a, ReadData2, 64'd0);
            end
        end
    endtask

    task automatic test_bypass();
        RegWrite = 1'b1; WriteRegister = 5'd7; WriteData = 64'h1234;
        ReadRegister1 = 5'd7; ReadRegister2 = 5'd7;
        #1;
        checks++;
        if (ReadData1 !== 64'h1234 || ReadData2 !== 64'h1234) begin
            errors++;
            $display("FAIL bypass_same rd1=%h rd2=%h exp=%h", ReadData1, ReadData2, 64'h1234);
        end
        tick();
        RegWrite = 1'b0; WriteData = 64'h5555;
        #1;
        checks++;
        if (ReadData1 !== 64'h1234 || ReadData2 !== 64'h1234) begin
            errors++;
            $display("FAIL bypass_next rd1=%h rd2=%h exp=%h", ReadData1, ReadData2, 64'h1234);
        end
    endtask

    task automatic test_zero_reg();
        RegWrite = 1'b1; WriteRegister = 5'd31; WriteData = 64'hFFFF_FFFF_FFFF_FFFF;
        ReadRegister1 = 5'd31;
        #1;
        checks++;
        if (ReadData1 !== 64'd0) begin
            errors++;
            $display("FAIL zero_same got=%h exp=%h", ReadData1, 64'd0);
        end
        tick();
        RegWrite = 1'b0;
        #1;
        checks++;
        if (ReadData1 !== 64'd0) begin
            errors++;
            $display("FAIL zero_next got=%h exp=%h", ReadData1, 64'd0);
        end
    endtask

    task automatic test_no_write();
        RegWrite = 1'b0; WriteRegister = 5'd3; WriteData = 64'hABCD;
        ReadRegister2 = 5'd3;
        #1;
        checks++;
        if (ReadData2 !== 64'd0) begin
            errors++;
            $display("FAIL nowrite_same got=%h exp=%h", ReadData2, 64'd0);
        end
        tick();
        #1;
        checks++;
        if (ReadData2 !== 64'd0) begin
            errors++;
            $display("FAIL nowrite_next got=%h exp=%h", ReadData2, 64'd0);
        end
    endtask

    task automatic test_reset_mid();
        RegWrite = 1'b1; WriteRegister = 5'd1; WriteData = 64'h11;
        tick();
        WriteRegister = 5'd2; WriteData = 64'h22;
        tick();
        // Reset on the same edge as a write of X1
        reset = 1'b1; WriteRegister = 5'd1; WriteData = 64'h99;
        ReadRegister1 = 5'd1; ReadRegister2 = 5'd2;
        #1;
        checks++;
        if (ReadData1 !== 64'h99) begin
            errors++;
            $display("FAIL rstmid_bypass got=%h exp=%h", ReadData1, 64'h99);
        end
        checks++;
        if (ReadData2 !== 64'h22) begin
            errors++;
            $display("FAIL rstmid_prereset got=%h exp=%h", ReadData2, 64'h22);
        end
        tick();
        reset = 1'b0; RegWrite = 1'b0;
        #1;
        checks++;
        if (ReadData1 !== 64'd0 || ReadData2 !== 64'd0) begin
            errors++;
            $display("FAIL rstmid_cleared rd1=%h rd2=%h exp=%h", ReadData1, ReadData2, 64'd0);
        end
    endtask

    task automatic test_random();
        logic [63:0] e1, e2;
        for (int n = 0; n < 400; n++) begin
            reset         = ($urandom_range(0, 31) == 0);
            RegWrite      = $urandom_range(0, 3) != 0;
            WriteRegister = 5'($urandom_range(0, 31));
            WriteData     = {$urandom, $urandom};
            // Bias reads toward the write address to exercise bypass
            ReadRegister1 = ($urandom_range(0, 3) == 0) ? WriteRegister : 5'($urandom_range(0, 31));
            ReadRegister2 = ($urandom_range(0, 3) == 0) ? ReadRegister1 : 5'($urandom_range(0, 31));
            #1;
            e1 = exp_rd(ReadRegister1);
            e2 = exp_rd(ReadRegister2);
            checks++;
            if (ReadData1 !== e1) begin
                errors++;
                $display("FAIL rand_rd1 n=%0d addr=%0d got=%h exp=%h", n, ReadRegister1, ReadData1, e1);
            end
            checks++;
            if (ReadData2 !== e2) begin
                errors++;
                $display("FAIL rand_rd2 n=%0d addr=%0d got=%h exp=%h", n, ReadRegister2, ReadData2, e2);
            end
            tick();
        end
        reset = 1'b0; RegWrite = 1'b0;
        // Final sweep of stored contents against the model
        for (int a = 0; a < 32; a++) begin
            ReadRegister1 = 5'(a);
            #1;
            checks++;
            if (ReadData1 !== exp_rd(5'(a))) begin
                errors++;
                $display("FAIL rand_sweep addr=%0d got=%h exp=%h", a, ReadData1, exp_rd(5'(a)));
            end
        end
    endtask

    initial begin
        errors = 0; checks = 0;
        reset = 1'b1; RegWrite = 1'b0; WriteRegister = 5'd0; WriteData = 64'd0;
        ReadRegister1 = 5'd0; ReadRegister2 = 5'd0;
        for (int i = 0; i < 32; i++) model[i] = 64'd0;
        #2;
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_no_write();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule : tb_regfile_wr_decode
`default_nettype wire
